alu_muldiv: RTL
===============

# alu_muldiv

Parametrised execute-stage ALU that extends the single-cycle integer ALU with an iterative multiply/divide unit and architectural HI/LO registers. Single-cycle ops produce a combinational result in the same cycle. MULT/MULTU/DIV/DIVU run for a fixed WIDTH+1 busy cycles behind a start/busy/done handshake, with a stall output for the pipeline. It sits in the EX stage between the ID/EX and EX/MEM registers; `cancel` is driven by the exception/flush logic.

## Interface
- `WIDTH`, 32: operand width; even, ≥ 4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `num1`, `num2`  in  WIDTH  source operands; `num1` is the dividend/multiplicand and the MTHI/MTLO data.
- `aluop`  in  4  operation: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT, 9 SLTU, 10 MULT, 11 MULTU, 12 DIV, 13 DIVU, 14 MFHI, 15 MFLO.
- `start`  in  1  qualifies `aluop` 10–13; ignored for other ops.
- `hi_wen`, `lo_wen`  in  1  MTHI/MTLO: write `num1` into HI/LO.
- `cancel`  in  1  abort an in-flight mul/div (pipeline flush).
- `result`  out  WIDTH  combinational result.
- `overflow`  out  1  signed overflow, ADD/SUB only.
- `zero`  out  1  `result == 0`.
- `busy`  out  1  registered; mul/div in flight.
- `done`  out  1  registered one-cycle pulse; HI/LO are updated and visible.
- `stall`  out  1  combinational: `busy | (start & aluop in 10..13)`.

## Operation
- ADD/ADDU/SUB/SUBU use modulo 2^WIDTH arithmetic. SUB is computed as `num1 + ~num2 + 1`.
- `overflow` for ADD: the operands have equal signs and the result sign differs. For SUB: the operand signs differ and the result sign differs from `num1`. `overflow` is 0 for all other ops.
- AND/OR/XOR/NOR are bitwise.
- SLT and SLTU return 1 or 0, zero-extended to WIDTH. SLT is a signed compare and must be correct on overflow: it uses the true sign, not `subr[MSB]` alone. SLTU is an unsigned compare.
- MFHI and MFLO return the current HI or LO register. During busy they return the old value; the pipeline must honour `stall`.
- For ops 10–13, `result` is 0.
- Mul/div FSM has three states: IDLE, RUN, FIX.
  - IDLE → RUN when `start` is high with op 10–13. At that edge, latch the operand magnitudes (absolute values for the signed ops), the result signs, and the op. Load a counter with WIDTH.
  - RUN runs one iteration per cycle; the counter decrements, and the FSM moves to FIX when the counter reaches 0.
  - Multiply is shift-add, one multiplier bit per cycle, into a 2·WIDTH product.
  - Divide is restoring, one quotient bit per cycle.
  - FIX applies the sign correction, writes HI/LO, and returns to IDLE with `done` = 1 for one cycle.
- Product: HI holds the upper half and LO the lower half. The signed product is the two's complement of the magnitude product when the operand signs differ.
- Divide: LO holds the quotient, truncated toward zero, and HI holds the remainder, which takes the sign of the dividend. The most-negative value divided by −1 gives LO = most-negative value and HI = 0.
- Divide by zero, signed or unsigned: LO = all ones and HI = `num1` as latched. No exception is raised.
- `hi_wen`/`lo_wen` write at the next edge only when `busy` is 0. When `busy` is 1 they are dropped. A write in the same cycle as an accepted `start` takes effect; the mul/div result later overwrites it.
- `start` while `busy` is ignored. `start` in the cycle `done` is high is accepted.
- `cancel` in RUN or FIX returns the FSM to IDLE at the next edge. HI/LO are unchanged and no `done` is produced. `cancel` in IDLE has priority over `start`.

## Timing
- Reset: state IDLE, HI = LO = 0, counter = 0, `busy` = `done` = 0. Mid-operation reset behaves like `cancel` and also clears HI/LO.
- Accepted `start` in cycle 0: `busy` = 1 in cycles 1 through WIDTH+1 (RUN for WIDTH cycles, FIX for 1). In cycle WIDTH+2, `done` = 1, `busy` = 0, and HI/LO hold the new values. For WIDTH = 32, `done` is in cycle 34.
- In cycle 0, `stall` = 1 combinationally. `stall` is 0 in the `done` cycle unless a new `start` is issued.
- Combinational ops have zero latency and work regardless of `busy`.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → `result` = 0x80000000, `overflow` = 1. ADDU with the same operands → `overflow` = 0. SLT 0x80000000, 0x00000001 → 1. SLTU with the same operands → 0.
- MULT 0xFFFFFFFF × 0x00000002 → `done` at cycle 34, HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. MULTU with the same operands → HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV 7 / −2 → LO = 0xFFFFFFFD, HI = 0x00000001. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 5 / 0 → LO = 0xFFFFFFFF, HI = 0x00000005. A second `start` issued during busy is ignored: exactly one `done`.
- Assert `cancel` at cycle 10 of a DIV → `busy` = 0 at cycle 11, no `done`, HI/LO keep their old values. Assert `lo_wen` during busy → dropped; MFLO during busy → returns the old LO.
- Assert `rst` mid-MULT → next cycle HI = LO = 0, `busy` = `done` = 0. Back-to-back `start` in the `done` cycle → second `done` exactly 34 cycles later.

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage integer ALU with an iterative multiply/divide unit
// and the architectural HI/LO registers.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [3:0]       aluop,
    input  logic             start,
    input  logic             hi_wen,
    input  logic             lo_wen,
    input  logic             cancel,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             stall
);
    localparam int M  = WIDTH - 1;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               isdiv;
    logic               qsgn;
    logic               rsgn;
    logic               dz;

    logic [WIDTH-1:0]   addr;
    logic [WIDTH-1:0]   subr;
    logic               slt;
    logic               mdop;
    logic               accept;
    logic [WIDTH-1:0]   a1;
    logic [WIDTH-1:0]   a2;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     rsh;
    logic               dge;
    logic [WIDTH-1:0]   rdiff;
    logic [2*WIDTH-1:0] fprod;
    logic [WIDTH-1:0]   fq;
    logic [WIDTH-1:0]   fr;

    assign mdop   = (aluop >= 4'd10) && (aluop <= 4'd13);
    assign accept = (state == S_IDLE) && start && mdop && !cancel;
    assign stall  = busy | (start & mdop);
    assign zero   = (result == '0);

    // Single-cycle datapath; SLT takes the true sign when the subtract overflows.
    always_comb begin
        addr     = num1 + num2;
        subr     = num1 + ~num2 + WIDTH'(1);
        slt      = (num1[M] != num2[M]) ? num1[M] : subr[M];
        result   = '0;
        overflow = 1'b0;
        case (aluop)
            4'd0: begin
                result   = addr;
                overflow = (num1[M] == num2[M]) && (addr[M] != num1[M]);
            end
            4'd1: result = addr;
            4'd2: begin
                result   = subr;
                overflow = (num1[M] != num2[M]) && (subr[M] != num1[M]);
            end
            4'd3:  result = subr;
            4'd4:  result = num1 & num2;
            4'd5:  result = num1 | num2;
            4'd6:  result = num1 ^ num2;
            4'd7:  result = ~(num1 | num2);
            4'd8:  result = {{M{1'b0}}, slt};
            4'd9:  result = {{M{1'b0}}, (num1 < num2)};
            4'd14: result = hi;
            4'd15: result = lo;
            default: result = '0;
        endcase
    end

    // Operand magnitudes, one shift-add / restoring step, and final sign fix.
    always_comb begin
        a1    = (num1[M] && !aluop[0]) ? -num1 : num1;
        a2    = (num2[M] && !aluop[0]) ? -num2 : num2;
        msum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? dvs : '0)};
        rsh   = {prod[2*WIDTH-1:WIDTH], prod[M]};
        dge   = (rsh >= {1'b0, dvs});
        rdiff = rsh[M:0] - dvs;
        fprod = qsgn ? -prod : prod;
        fq    = dz ? '1 : (qsgn ? -prod[M:0] : prod[M:0]);
        fr    = rsgn ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    end

    // Mul/div sequencer plus HI/LO register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            prod  <= '0;
            dvs   <= '0;
            hi    <= '0;
            lo    <= '0;
            isdiv <= 1'b0;
            qsgn  <= 1'b0;
            rsgn  <= 1'b0;
            dz    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy && hi_wen) hi <= num1;
            if (!busy && lo_wen) lo <= num1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        cnt   <= CW'(WIDTH);
                        prod  <= {{WIDTH{1'b0}}, a1};
                        dvs   <= a2;
                        isdiv <= aluop[2];
                        qsgn  <= !aluop[0] && (num1[M] ^ num2[M]);
                        rsgn  <= !aluop[0] && num1[M];
                        dz    <= (num2 == '0);
                    end
                end
                S_RUN: begin
                    if (cancel) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (isdiv)
                            prod <= {(dge ? rdiff : rsh[M:0]), prod[M-1:0], dge};
                        else
                            prod <= {msum, prod[M:1]};
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    if (!cancel) begin
                        done <= 1'b1;
                        if (isdiv) begin
                            hi <= fr;
                            lo <= fq;
                        end else begin
                            hi <= fprod[2*WIDTH-1:WIDTH];
                            lo <= fprod[M:0];
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
